ram_delay_line: RTL and testbench
=================================

Name: ram_delay_line

Overview:
- Runtime-programmable N-bit delay line backed by a circular buffer in block RAM.
- Functionally equivalent to the register-chain delay line, with the delay length set by an input port instead of a parameter (range 1..DEPTH).
- Used in the vision pipeline to re-align a side-band pixel or flag stream with a long-latency processing path whose latency is configured at run time.
- Writer side: a pointer that advances per ce. Reader side: an address that trails the writer by the programmed delay.

Parameters:
- N, 8, data width in bits.
- DEPTH, 1024, maximum delay in ce-cycles. Must be a power of two and >= 2.
- AW, $clog2(DEPTH), address width (derived; not to be overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- ce  in  1  clock enable; one sample is accepted and one is shifted out per cycle with ce=1.
- delay  in  AW+1  requested delay in ce-cycles.
- data  in  N  input sample.
- outp  out  N  delayed sample.
- out_valid  out  1  outp holds a genuinely delayed sample; low while the buffer is refilling.

Behaviour:
- Reset (rst=0 at a clk edge):
  - wr_ptr=0, outp=0, out_valid=0, fill=0, delay_q=1.
  - No RAM write occurs, even if ce=1.
  - RAM contents are not cleared; out_valid masks stale data.
  - Reset applies mid-stream the same way.
- Delay clamping to delay_eff:
  - delay=0 -> 1.
  - delay>DEPTH -> DEPTH.
  - Otherwise delay.
- delay_q is the registered effective delay, compared on every clk edge, independent of ce.
- Delay change (delay_eff != delay_q at an edge):
  - delay_q <= delay_eff.
  - fill <= ce ? 1 : 0.
  - out_valid <= (ce && delay_eff==1).
  - Any ce activity in the same cycle uses the new delay.
- Per ce=1 edge (rst=1):
  - mem[wr_ptr] <= data.
  - wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
  - outp <= (d==1) ? data : mem[wr_ptr - d + 1] mod DEPTH, where d is the delay in force (new value if changing).
  - The d==1 bypass avoids read-during-write on the same address.
- Timing contract: after k ce-edges, outp equals the data presented at ce-edge k-d+1, i.e. the same as the register-chain delay line with DELAY=d.
- Latency is counted in ce-edges, not clk cycles.
- Fill counter:
  - fill saturates at d; increments per ce edge while fill<d.
  - out_valid is registered: high at the edge where fill reaches d (the d-th ce edge after reset or delay change), and stays high until the next reset or change.
- ce=0: wr_ptr, outp, out_valid and fill hold. A delay change is still processed.
- Wrap-around: at d=DEPTH the read address is wr_ptr+1, the oldest entry, never the address being written. No collision for any d in 1..DEPTH.
- RAM read is synchronous: one read port and one write port, same clock. outp is the RAM output register, so there is no extra pipeline stage.

Decomposition:
- No shared package needed. The clamp logic is local.
- One sub-module: sdp_ram (simple dual-port, parameters N and AW; write port we/waddr/wdata; registered read port re/raddr/rdata, with re=ce).
- Top level holds wr_ptr, delay_q, fill, out_valid, the bypass mux and the clamp.

Test Plan (DEPTH=16, N=8 in bench):
- delay=1, ce=1 continuously, data=0x01,0x02,0x03 -> outp=0x01,0x02,0x03 on the same edges; out_valid=1 from the first edge.
- delay=5, data ramp 0x00.. -> out_valid rises on the 5th ce edge with outp=0x00; the 6th edge gives outp=0x01.
- delay=4, ce toggling 1,0,0,1,... -> outp and out_valid frozen on ce=0 cycles; sequence equals the ce-only sample stream delayed 4 samples.
- delay=16, 40-sample ramp -> outp at ce-edge k = k-15 for k>=16; correct across pointer wrap. delay=20 behaves identically to 16 (clamp).
- Change delay 3->7 at sample 10 -> out_valid low for 6 ce edges, high on the 7th with outp=sample 10. delay=0 behaves as 1.
- rst=0 for one cycle mid-stream with ce=1 -> next edge outp=0x00, out_valid=0, no write. After release with delay=2, the first valid output is the first post-reset sample.

Source files
------------

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port on the same clock.
// Inferable as block RAM. Contents are not reset.
//
// Ports:
//   clk_i    system clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   re_i     read enable; rdata_o is updated only when set
//   raddr_i  read address
//   rdata_o  registered read data
module sdp_ram #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem [2**AW];
  logic [N-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_delay_line.sv
// Runtime-programmable delay line backed by a circular buffer in block RAM.
// The writer pointer advances once per ce; the reader address trails it by the
// programmed delay. Latency is counted in ce-edges.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   ce         clock enable; one sample in and one sample out per ce cycle
//   delay      requested delay (clamped into 1..DEPTH)
//   data       input sample
//   outp       delayed sample
//   out_valid  outp holds a genuinely delayed sample (low while refilling)
module ram_delay_line #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [AW:0]   delay,
  input  logic [N-1:0]  data,
  output logic [N-1:0]  outp,
  output logic          out_valid
);

  localparam logic [AW:0] MaxDelay = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneDelay = (AW+1)'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   delay_q, delay_eff;
  logic [AW:0]   fill_q, fill_d;
  logic          out_valid_q, out_valid_d;
  logic          bypass_q, bypass_d;
  logic [N-1:0]  byp_data_q, byp_data_d;
  logic          delay_chg;
  logic [AW-1:0] raddr;
  logic [N-1:0]  rdata;

  // Clamp the requested delay into the supported range.
  always_comb begin
    if (delay == '0) begin
      delay_eff = OneDelay;
    end else if (delay > MaxDelay) begin
      delay_eff = MaxDelay;
    end else begin
      delay_eff = delay;
    end
  end

  assign delay_chg = (delay_eff != delay_q);

  // delay_eff equals delay_q unless a change is in progress, in which case the
  // new value is the one in force, so the read address always uses delay_eff.
  // At delay DEPTH the low bits are zero and the read lands on wr_ptr+1.
  assign raddr = wr_ptr_q + AW'(1) - delay_eff[AW-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    bypass_d    = bypass_q;
    byp_data_d  = byp_data_q;

    if (ce) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      // Delay 1 would read the address being written; take the input directly.
      bypass_d   = (delay_eff == OneDelay);
      byp_data_d = data;
    end

    if (delay_chg) begin
      fill_d      = ce ? OneDelay : '0;
      out_valid_d = ce && (delay_eff == OneDelay);
    end else if (ce) begin
      if (fill_q < delay_eff) begin
        fill_d = fill_q + OneDelay;
      end
      out_valid_d = (fill_d == delay_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      delay_q     <= OneDelay;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      // Selecting the zeroed bypass register forces outp to zero out of reset.
      bypass_q    <= 1'b1;
      byp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_eff;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      bypass_q    <= bypass_d;
      byp_data_q  <= byp_data_d;
    end
  end

  sdp_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ce && rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (data),
    .re_i    (ce),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign outp      = bypass_q ? byp_data_q : rdata;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_delay_line.sv
module tb_ram_delay_line;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce  = 1'b0;
  logic [AW:0]   delay = 5'd1;
  logic [N-1:0]  data  = '0;
  logic [N-1:0]  outp;
  logic          out_valid;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ram_delay_line #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .delay     (delay),
    .data      (data),
    .outp      (outp),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    ce   = 1'b1;
    data = 8'hA5;
    tick();
    rst  = 1'b1;
  endtask

  initial begin
    int j;
    logic       ev;
    logic [7:0] eo;

    // Reset state
    rst = 1'b0; ce = 1'b1; delay = 5'd1; data = 8'hAA;
    tick();
    tick();
    check("rst_outp", 32'(outp), 32'h00);
    check("rst_valid", 32'(out_valid), 32'h0);

    // Delay 1: same-edge bypass, valid from the first edge
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data = 8'(i);
      tick();
      check("d1_outp", 32'(outp), 32'(i));
      check("d1_valid", 32'(out_valid), 32'h1);
    end

    // Delay 5 with a ramp starting at 0
    do_reset();
    delay = 5'd5;
    for (int k = 1; k <= 7; k++) begin
      data = 8'(k - 1);
      tick();
      check("d5_valid", 32'(out_valid), (k >= 5) ? 32'h1 : 32'h0);
      if (k >= 5) check("d5_outp", 32'(outp), 32'(k - 5));
    end

    // Delay 4 with ce pattern 1,0,0: outputs freeze on idle cycles
    do_reset();
    delay = 5'd4;
    j = 0; ev = 1'b0; eo = 8'h00;
    for (int i = 0; i < 24; i++) begin
      ce   = (i % 3 == 0);
      data = ce ? 8'(8'h40 + j) : 8'hEE;
      tick();
      if (ce) begin
        j++;
        if (j >= 4) begin
          ev = 1'b1;
          eo = 8'(8'h40 + j - 4);
        end
      end
      check("ce_valid", 32'(out_valid), 32'(ev));
      if (ev) check("ce_outp", 32'(outp), 32'(eo));
    end
    ce = 1'b1;

    // Full depth across pointer wrap, then an over-range request clamped to it
    for (int p = 0; p < 2; p++) begin
      do_reset();
      delay = (p == 0) ? 5'd16 : 5'd20;
      for (int k = 1; k <= 40; k++) begin
        data = 8'(k);
        tick();
        check("d16_valid", 32'(out_valid), (k >= 16) ? 32'h1 : 32'h0);
        if (k >= 16) check("d16_outp", 32'(outp), 32'(k - 15));
      end
    end

    // Delay 3 changed to 7 at sample 10
    do_reset();
    delay = 5'd3;
    for (int s = 0; s < 18; s++) begin
      if (s == 10) delay = 5'd7;
      data = 8'(s);
      tick();
      if (s < 10) begin
        check("chg_valid_a", 32'(out_valid), (s >= 2) ? 32'h1 : 32'h0);
        if (s >= 2) check("chg_outp_a", 32'(outp), 32'(s - 2));
      end else begin
        check("chg_valid_b", 32'(out_valid), (s >= 16) ? 32'h1 : 32'h0);
        if (s >= 16) check("chg_outp_b", 32'(outp), 32'(s - 6));
      end
    end

    // Delay 0 behaves as 1
    delay = 5'd0;
    data  = 8'h90;
    tick();
    check("d0_outp", 32'(outp), 32'h90);
    check("d0_valid", 32'(out_valid), 32'h1);
    data = 8'h91;
    tick();
    check("d0_outp2", 32'(outp), 32'h91);

    // Mid-stream reset with ce high, then delay 2 after release
    delay = 5'd2;
    for (int i = 0; i < 4; i++) begin
      data = 8'(8'h30 + i);
      tick();
    end
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    check("pre_rst_outp", 32'(outp), 32'h32);
    rst = 1'b0; ce = 1'b1; data = 8'h77;
    tick();
    check("mid_rst_outp", 32'(outp), 32'h00);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b1;
    data = 8'h20;
    tick();
    check("post_rst_valid1", 32'(out_valid), 32'h0);
    data = 8'h21;
    tick();
    check("post_rst_valid2", 32'(out_valid), 32'h1);
    check("post_rst_outp2", 32'(outp), 32'h20);
    data = 8'h22;
    tick();
    check("post_rst_outp3", 32'(outp), 32'h21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
